// File: rtl/ro_scan_if.sv
// Result handshake bundle between the ring-oscillator scan controller and the
// register block that consumes (index, count) results.
interface ro_scan_if #(
  parameter int SEL_W = 4,
  parameter int CNT_W = 16
) ();
  logic             res_valid_o;
  logic             res_ready_i;
  logic [SEL_W-1:0] res_idx_o;
  logic [CNT_W-1:0] res_cnt_o;
  logic             res_ovf_o;

  modport master (
    output res_valid_o, res_idx_o, res_cnt_o, res_ovf_o,
    input  res_ready_i
  );

  modport slave (
    input  res_valid_o, res_idx_o, res_cnt_o, res_ovf_o,
    output res_ready_i
  );
endinterface

// File: rtl/ro_scan_controller.sv
// Ring-oscillator bank scanner: walks the enabled oscillators in index order,
// steers the output mux, lets it settle, counts synchronised rising edges over
// a programmable window and hands each result out on a valid/ready port.
module ro_scan_controller #(
  parameter int N_RO       = 16,
  parameter int SEL_W      = 4,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             start_i,
  input  logic             continuous_i,
  input  logic             abort_i,
  input  logic [N_RO-1:0]  en_mask_i,
  input  logic [WIN_W-1:0] win_len_i,
  input  logic             ro_in_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             busy_o,
  output logic             done_o,
  ro_scan_if.master        res
);

  // Pointer needs one extra bit so N_RO can mean "past the last oscillator".
  localparam int PTR_W = SEL_W + 1;

  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, COUNT, REPORT} state_t;

  state_t           state;
  logic [N_RO-1:0]  mask_q;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] tmr;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [2:0]       sync;
  logic             rise;
  logic             found;
  logic [SEL_W-1:0] found_idx;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;

  // Two-flop synchroniser plus an edge-detect flop; runs in every state.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) sync <= '0;
    else             sync <= {sync[1:0], ro_in_i};
  end

  assign rise   = sync[1] & ~sync[2];
  assign busy_o = (state != IDLE);

  // Lowest enabled oscillator at or above the pointer (downward loop keeps the lowest).
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = N_RO - 1; i >= 0; i--) begin
      if (mask_q[i] && (i >= int'(ptr))) begin
        found     = 1'b1;
        found_idx = SEL_W'(i);
      end
    end
  end

  // Saturating edge counter; ovf marks an edge that could not be counted.
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (rise) begin
      if (cnt == {CNT_W{1'b1}}) ovf_nxt = 1'b1;
      else                      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Scan sequencer; abort outranks everything but reset and leaves sel_o alone.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state           <= IDLE;
      sel_o           <= '0;
      done_o          <= 1'b0;
      mask_q          <= '0;
      win_q           <= '0;
      tmr             <= '0;
      ptr             <= '0;
      cnt             <= '0;
      ovf             <= 1'b0;
      res.res_valid_o <= 1'b0;
      res.res_idx_o   <= '0;
      res.res_cnt_o   <= '0;
      res.res_ovf_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (abort_i) begin
        state           <= IDLE;
        res.res_valid_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              mask_q <= en_mask_i;
              win_q  <= (win_len_i == '0) ? WIN_W'(1) : win_len_i;
              ptr    <= '0;
              state  <= SELECT;
            end
          end
          SELECT: begin
            if (found) begin
              sel_o <= found_idx;
              cnt   <= '0;
              ovf   <= 1'b0;
              tmr   <= WIN_W'(SETTLE_CYC - 1);
              state <= SETTLE;
            end else if (continuous_i && (mask_q != '0)) begin
              ptr <= '0;
            end else begin
              done_o <= 1'b1;
              state  <= IDLE;
            end
          end
          SETTLE: begin
            if (tmr == '0) begin
              tmr   <= win_q - WIN_W'(1);
              state <= COUNT;
            end else begin
              tmr <= tmr - WIN_W'(1);
            end
          end
          COUNT: begin
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
            if (tmr == '0) begin
              res.res_idx_o   <= sel_o;
              res.res_cnt_o   <= cnt_nxt;
              res.res_ovf_o   <= ovf_nxt;
              res.res_valid_o <= 1'b1;
              state           <= REPORT;
            end else begin
              tmr <= tmr - WIN_W'(1);
            end
          end
          REPORT: begin
            if (res.res_ready_i) begin
              res.res_valid_o <= 1'b0;
              ptr             <= PTR_W'(res.res_idx_o) + PTR_W'(1);
              state           <= SELECT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ro_scan_controller.sv
// Directed bench for ro_scan_controller: a default instance plus a 4-bit
// counter instance driven by the same stimulus for the saturation case.
module tb_ro_scan_controller;

  localparam int SETTLE = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] mask = '0;
  logic [15:0] win = '0;
  logic        ro;
  logic        ready = 1'b1;
  logic [1:0]  ro_ph = '0;
  logic [3:0]  sel, sel4;
  logic        busy, busy4, done, done4;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int hs_cnt = 0;

  ro_scan_if #(.SEL_W(4), .CNT_W(16)) rif ();
  ro_scan_if #(.SEL_W(4), .CNT_W(4))  rif4 ();

  assign rif.res_ready_i  = ready;
  assign rif4.res_ready_i = ready;
  assign ro = ro_ph[1];

  ro_scan_controller dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start), .continuous_i(cont),
    .abort_i(abort), .en_mask_i(mask), .win_len_i(win), .ro_in_i(ro),
    .sel_o(sel), .busy_o(busy), .done_o(done), .res(rif.master)
  );

  ro_scan_controller #(.CNT_W(4)) dut4 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start), .continuous_i(cont),
    .abort_i(abort), .en_mask_i(mask), .win_len_i(win), .ro_in_i(ro),
    .sel_o(sel4), .busy_o(busy4), .done_o(done4), .res(rif4.master)
  );

  always #5 clk = ~clk;

  // Oscillator stand-in: square wave at clk/4.
  always @(posedge clk) ro_ph <= ro_ph + 2'd1;

  // Event counters sampled at the edge where they take effect.
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (rif.res_valid_o && rif.res_ready_i) hs_cnt <= hs_cnt + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_scan(input logic [15:0] m, input logic [15:0] w);
    @(negedge clk);
    mask  = m;
    win   = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (rif.res_valid_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sel !== 4'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    checks++; if (rif.res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", rif.res_valid_o); end
    checks++; if (rif.res_idx_o !== 4'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", rif.res_idx_o); end
    checks++; if (rif.res_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", rif.res_cnt_o); end
    checks++; if (rif.res_ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", rif.res_ovf_o); end
  endtask

  task automatic test_scan();
    int n;
    int d0;
    int h0;
    d0 = done_cnt; h0 = hs_cnt;
    ready = 1'b1; cont = 1'b0;
    start_scan(16'h0005, 16'd100);
    wait_valid(400, n);
    checks++; if (n !== 1 + SETTLE + 100) begin errors++; $display("FAIL scan_latency got %0d exp %0d", n, 1 + SETTLE + 100); end
    checks++; if (rif.res_idx_o !== 4'd0) begin errors++; $display("FAIL scan_idx0 got %0d exp 0", rif.res_idx_o); end
    checks++; if (sel !== 4'd0) begin errors++; $display("FAIL scan_sel0 got %0d exp 0", sel); end
    checks++; if (rif.res_cnt_o < 16'd24 || rif.res_cnt_o > 16'd26) begin errors++; $display("FAIL scan_cnt0 got %0d exp 25+/-1", rif.res_cnt_o); end
    checks++; if (rif.res_ovf_o !== 1'b0) begin errors++; $display("FAIL scan_ovf0 got %0b exp 0", rif.res_ovf_o); end
    @(negedge clk);
    wait_valid(400, n);
    checks++; if (rif.res_valid_o !== 1'b1) begin errors++; $display("FAIL scan_timeout2 got %0b exp 1", rif.res_valid_o); end
    checks++; if (rif.res_idx_o !== 4'd2) begin errors++; $display("FAIL scan_idx2 got %0d exp 2", rif.res_idx_o); end
    checks++; if (sel !== 4'd2) begin errors++; $display("FAIL scan_sel2 got %0d exp 2", sel); end
    checks++; if (rif.res_cnt_o < 16'd24 || rif.res_cnt_o > 16'd26) begin errors++; $display("FAIL scan_cnt2 got %0d exp 25+/-1", rif.res_cnt_o); end
    repeat (6) @(negedge clk);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL scan_done_pulses got %0d exp 1", done_cnt - d0); end
    checks++; if (hs_cnt - h0 !== 2) begin errors++; $display("FAIL scan_results got %0d exp 2", hs_cnt - h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL scan_idle got %0b exp 0", busy); end
  endtask

  task automatic test_empty(input logic c);
    int h0;
    h0 = hs_cnt;
    cont = c;
    start_scan(16'h0000, 16'd10);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL empty_busy got %0b exp 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_early_done got %0b exp 0", done); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_done got %0b exp 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_idle got %0b exp 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_done_width got %0b exp 0", done); end
    repeat (5) @(negedge clk);
    checks++; if (hs_cnt !== h0 || rif.res_valid_o !== 1'b0) begin errors++; $display("FAIL empty_no_result got %0d exp %0d", hs_cnt, h0); end
    cont = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    int h0;
    int d0;
    int unstable;
    logic [3:0]  idx0;
    logic [15:0] cnt0;
    ready = 1'b0; cont = 1'b0;
    start_scan(16'h0001, 16'd40);
    wait_valid(200, n);
    checks++; if (rif.res_valid_o !== 1'b1) begin errors++; $display("FAIL bp_timeout got %0b exp 1", rif.res_valid_o); end
    idx0 = rif.res_idx_o; cnt0 = rif.res_cnt_o; h0 = hs_cnt; d0 = done_cnt;
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rif.res_valid_o !== 1'b1 || rif.res_idx_o !== idx0 || rif.res_cnt_o !== cnt0) unstable++;
    end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d changed cycles exp 0", unstable); end
    checks++; if (cnt0 < 16'd9 || cnt0 > 16'd11) begin errors++; $display("FAIL bp_cnt got %0d exp 10+/-1", cnt0); end
    ready = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (hs_cnt - h0 !== 1) begin errors++; $display("FAIL bp_one_result got %0d exp 1", hs_cnt - h0); end
    checks++; if (rif.res_valid_o !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got %0b exp 0", rif.res_valid_o); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL bp_done got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_saturate();
    int n;
    ready = 1'b1; cont = 1'b0;
    start_scan(16'h0001, 16'd100);
    wait_valid(400, n);
    checks++; if (rif4.res_valid_o !== 1'b1) begin errors++; $display("FAIL sat_valid got %0b exp 1", rif4.res_valid_o); end
    checks++; if (rif4.res_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d exp 15", rif4.res_cnt_o); end
    checks++; if (rif4.res_ovf_o !== 1'b1) begin errors++; $display("FAIL sat_ovf got %0b exp 1", rif4.res_ovf_o); end
    checks++; if (rif.res_ovf_o !== 1'b0) begin errors++; $display("FAIL sat_wide_ovf got %0b exp 0", rif.res_ovf_o); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_continuous();
    int n;
    int d0;
    logic [3:0] exp_idx [4];
    exp_idx[0] = 4'd0; exp_idx[1] = 4'd15; exp_idx[2] = 4'd0; exp_idx[3] = 4'd15;
    d0 = done_cnt;
    ready = 1'b1; cont = 1'b1;
    start_scan(16'h8001, 16'd4);
    for (int r = 0; r < 4; r++) begin
      wait_valid(100, n);
      checks++; if (rif.res_valid_o !== 1'b1 || rif.res_idx_o !== exp_idx[r]) begin errors++; $display("FAIL cont_idx%0d got %0d exp %0d", r, rif.res_idx_o, exp_idx[r]); end
      if (r == 2) cont = 1'b0;
      @(negedge clk);
    end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL cont_no_early_done got %0d exp %0d", done_cnt, d0); end
    repeat (4) @(negedge clk);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL cont_done got %0d exp 1", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_idle got %0b exp 0", busy); end
  endtask

  task automatic test_abort();
    int n;
    int d0;
    int h0;
    // Abort while counting
    d0 = done_cnt; h0 = hs_cnt;
    ready = 1'b1; cont = 1'b0;
    start_scan(16'h0004, 16'd100);
    repeat (30) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_cnt_busy got %0b exp 0", busy); end
    checks++; if (sel !== 4'd2) begin errors++; $display("FAIL abort_cnt_sel got %0d exp 2", sel); end
    repeat (120) @(negedge clk);
    checks++; if (done_cnt !== d0 || hs_cnt !== h0) begin errors++; $display("FAIL abort_cnt_quiet got %0d exp %0d", done_cnt + hs_cnt, d0 + h0); end
    // Abort while holding a result
    ready = 1'b0;
    start_scan(16'h0004, 16'd10);
    wait_valid(100, n);
    checks++; if (rif.res_valid_o !== 1'b1) begin errors++; $display("FAIL abort_rep_timeout got %0b exp 1", rif.res_valid_o); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (rif.res_valid_o !== 1'b0) begin errors++; $display("FAIL abort_rep_valid got %0b exp 0", rif.res_valid_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_rep_busy got %0b exp 0", busy); end
    checks++; if (sel !== 4'd2) begin errors++; $display("FAIL abort_rep_sel got %0d exp 2", sel); end
    ready = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (done_cnt !== d0 || hs_cnt !== h0) begin errors++; $display("FAIL abort_rep_quiet got %0d exp %0d", done_cnt + hs_cnt, d0 + h0); end
    // Reset while counting
    start_scan(16'h0004, 16'd100);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++; if (sel !== 4'd0) begin errors++; $display("FAIL rst_sel got %0d exp 0", sel); end
    checks++; if (rif.res_idx_o !== 4'd0) begin errors++; $display("FAIL rst_idx got %0d exp 0", rif.res_idx_o); end
    checks++; if (rif.res_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", rif.res_cnt_o); end
    checks++; if (rif.res_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", rif.res_valid_o); end
    repeat (120) @(negedge clk);
    checks++; if (done_cnt !== d0 || hs_cnt !== h0) begin errors++; $display("FAIL rst_quiet got %0d exp %0d", done_cnt + hs_cnt, d0 + h0); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_empty(1'b0);
    test_empty(1'b1);
    test_backpressure();
    test_saturate();
    test_continuous();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
